// File: rtl/sa_row_writer_pkg.sv
// rtl/sa_row_writer_pkg.sv - shared types and default sizing for the row writer
package sa_row_writer_pkg;

  // Default geometry of the comb_SA output memory.
  localparam int DEF_DAT_W = 8;
  localparam int DEF_DAT_D = 12;

  // Batch collection states.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/sa_row_writer.sv
// rtl/sa_row_writer.sv - captures systolic-array row batches into the mem write port
module sa_row_writer
  import sa_row_writer_pkg::*;
#(
  parameter int DAT_W = DEF_DAT_W,
  parameter int DAT_D = DEF_DAT_D,
  parameter int ROWS  = DAT_D / 3,
  localparam int AW   = (DAT_D > 1) ? $clog2(DAT_D) : 1,
  localparam int CW   = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DAT_W-1:0] in_data,
  input  logic             clr_err,
  output logic             wren,
  output logic [AW-1:0]    wraddress,
  output logic [DAT_W-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err_orphan,
  output logic             err_short
);

  state_e           state_q, state_d;
  logic [CW-1:0]    row_cnt_q, row_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             wren_q, wren_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DAT_W-1:0] wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             orphan_q, orphan_d;
  logic             short_q, short_d;

  logic             take;
  logic [CW-1:0]    cnt_new;

  // Next-state: decide whether this word is written, how the batch count moves,
  // and which protocol errors it raises. A new error beats a same-cycle clear.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    wren_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    orphan_d  = orphan_q & ~clr_err;
    short_d   = short_q & ~clr_err;
    take      = 1'b0;
    cnt_new   = row_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (start) begin
            take    = 1'b1;
            cnt_new = CW'(1);
          end else begin
            orphan_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          take = 1'b1;
          if (start) begin
            // Partial batch is abandoned; this word restarts the count.
            short_d = 1'b1;
            cnt_new = CW'(1);
          end else begin
            cnt_new = row_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      wren_d   = 1'b1;
      waddr_d  = wr_ptr_q;
      wdata_d  = in_data;
      wr_ptr_d = (wr_ptr_q == AW'(DAT_D - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (cnt_new == CW'(ROWS)) begin
        done_d    = 1'b1;
        state_d   = S_IDLE;
        row_cnt_d = '0;
      end else begin
        state_d   = S_COLLECT;
        row_cnt_d = cnt_new;
      end
    end
  end

  // State and registered write port; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      wr_ptr_q  <= '0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      orphan_q  <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      orphan_q  <= orphan_d;
      short_q   <= short_d;
    end
  end

  assign wren       = wren_q;
  assign wraddress  = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = (state_q == S_COLLECT);
  assign done       = done_q;
  assign err_orphan = orphan_q;
  assign err_short  = short_q;

endmodule
